// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and baud divider maths.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clock cycles per oversample tick, rounded to nearest.
   function automatic int uart_div(input int clk_hz, input int baud, input int ovs);
      longint den;
      den = longint'(baud) * longint'(ovs);
      return int'((longint'(clk_hz) + den / 2) / den);
   endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Word handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_ovs_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rdata;
   logic                 rvalid;
   logic                 rready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 break_det;
   logic                 overrun;

   modport master (
      output rdata, rvalid, frame_err, parity_err, break_det, overrun,
      input  rready
   );

   modport slave (
      input  rdata, rvalid, frame_err, parity_err, break_det, overrun,
      output rready
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
module uart_baud_tick #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TOP = CW'(DIV - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt_reg <= '0;
      end else if (cnt_reg == TOP) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   assign tick = (cnt_reg == TOP);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: input synchroniser, 2-of-3 majority bit sampling, frame FSM
// and error/overrun reporting presented on a valid/ready word interface.
module uart_rx_ovs
   import uart_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int BAUD        = 115_200,
   parameter int OVS         = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = PAR_NONE,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx,
   uart_rx_ovs_if.master rx_if
);
   localparam int DIV = uart_div(CLK_HZ, BAUD, OVS);
   localparam int OW  = $clog2(OVS);
   localparam int BW  = $clog2(DATA_BITS + 1);

   localparam logic [OW-1:0] SMP_LO  = OW'(OVS / 2 - 1);
   localparam logic [OW-1:0] SMP_MID = OW'(OVS / 2);
   localparam logic [OW-1:0] SMP_HI  = OW'(OVS / 2 + 1);
   localparam logic [OW-1:0] SMP_END = OW'(OVS - 1);

   generate
      if (DIV < 1 || OVS < 8 || (OVS % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
          PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2)
      begin : g_bad_params
         $error("uart_rx_ovs: unsupported parameter combination");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rx_s;
   logic                   rx_prev_reg;

   uart_rx_state_t         state_reg;
   logic [OW-1:0]          ovs_reg;
   logic [BW-1:0]          bit_reg;
   logic [1:0]             samp_reg;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   par_err_reg;
   logic                   frame_reg;
   logic                   zero_reg;
   logic                   drop_reg;
   logic                   break_wait_reg;

   logic [DATA_BITS-1:0]   rdata_reg;
   logic                   rvalid_reg;
   logic                   frame_err_reg;
   logic                   parity_err_reg;
   logic                   break_det_reg;
   logic                   overrun_reg;

   logic tick;
   logic tick_restart;
   logic vote;
   logic fall;
   logic mid_tick;
   logic end_tick;
   logic exp_par;
   logic frame_now;
   logic zero_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '1;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_reg[SYNC_STAGES-1];

   assign tick_restart = (state_reg == ST_IDLE);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (tick_restart),
      .tick    (tick)
   );

   // The third sample is the live synchronised line at the decision tick.
   assign vote      = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
   assign fall      = rx_prev_reg & ~rx_s;
   assign mid_tick  = tick && (ovs_reg == SMP_HI);
   assign end_tick  = tick && (ovs_reg == SMP_END);
   assign exp_par   = (PARITY == PAR_ODD) ? ~(^shift_reg) : ^shift_reg;
   assign frame_now = frame_reg | ~vote;
   assign zero_now  = zero_reg & ~vote;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_prev_reg    <= 1'b1;
         state_reg      <= ST_IDLE;
         ovs_reg        <= '0;
         bit_reg        <= '0;
         samp_reg       <= '0;
         shift_reg      <= '0;
         par_err_reg    <= 1'b0;
         frame_reg      <= 1'b0;
         zero_reg       <= 1'b0;
         drop_reg       <= 1'b0;
         break_wait_reg <= 1'b0;
         rdata_reg      <= '0;
         rvalid_reg     <= 1'b0;
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
         break_det_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         rx_prev_reg <= rx_s;

         if (rvalid_reg && rx_if.rready) begin
            rvalid_reg <= 1'b0;
         end

         if (tick) begin
            ovs_reg <= (ovs_reg == SMP_END) ? '0 : ovs_reg + OW'(1);
            if (ovs_reg == SMP_LO) begin
               samp_reg[0] <= rx_s;
            end
            if (ovs_reg == SMP_MID) begin
               samp_reg[1] <= rx_s;
            end
         end

         case (state_reg)
            ST_IDLE: begin
               ovs_reg <= '0;
               if (rx_s) begin
                  break_wait_reg <= 1'b0;
               end
               if (fall && !break_wait_reg) begin
                  state_reg   <= ST_START;
                  bit_reg     <= '0;
                  shift_reg   <= '0;
                  par_err_reg <= 1'b0;
                  frame_reg   <= 1'b0;
                  zero_reg    <= 1'b1;
               end
            end

            ST_START: begin
               if (mid_tick && vote) begin
                  state_reg <= ST_IDLE;
               end else if (end_tick) begin
                  state_reg <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (mid_tick) begin
                  shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                  zero_reg  <= zero_now;
                  bit_reg   <= bit_reg + BW'(1);
               end
               if (end_tick && bit_reg == BW'(DATA_BITS)) begin
                  state_reg <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  bit_reg   <= '0;
               end
            end

            ST_PARITY: begin
               if (mid_tick) begin
                  par_err_reg <= (vote != exp_par);
                  zero_reg    <= zero_now;
               end
               if (end_tick) begin
                  state_reg <= ST_STOP;
               end
            end

            ST_STOP: begin
               if (mid_tick) begin
                  if (bit_reg == BW'(STOP_BITS - 1)) begin
                     // Leave mid-bit so a back-to-back start edge is not missed.
                     state_reg      <= ST_IDLE;
                     break_wait_reg <= zero_now;
                     if (!rvalid_reg || rx_if.rready) begin
                        rdata_reg      <= shift_reg;
                        rvalid_reg     <= 1'b1;
                        frame_err_reg  <= frame_now;
                        parity_err_reg <= par_err_reg;
                        break_det_reg  <= zero_now;
                        overrun_reg    <= drop_reg;
                        drop_reg       <= 1'b0;
                     end else begin
                        drop_reg <= 1'b1;
                     end
                  end else begin
                     frame_reg <= frame_now;
                     zero_reg  <= zero_now;
                     bit_reg   <= bit_reg + BW'(1);
                  end
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_if.rdata      = rdata_reg;
   assign rx_if.rvalid     = rvalid_reg;
   assign rx_if.frame_err  = frame_err_reg;
   assign rx_if.parity_err = parity_err_reg;
   assign rx_if.break_det  = break_det_reg;
   assign rx_if.overrun    = overrun_reg;

endmodule
